// File: rtl/mem_copy_engine.sv
// Small DMA engine for the dual-port data memory: copies (port 1 -> port 2) or fills
// a block of bytes, one byte per cycle, and reports an 8-bit checksum of the bytes written.
module mem_copy_engine #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] length,
  input  logic [DW-1:0] fill_value,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum,
  output logic [AW-1:0] address_1,
  output logic          memread_1,
  output logic          memwrite_1,
  output logic [DW-1:0] write_data_1,
  input  logic [DW-1:0] read_data_1,
  output logic [AW-1:0] address_2,
  output logic          memwrite_2,
  output logic          memread_2,
  output logic [DW-1:0] write_data_2
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state, state_next;
  logic          mode_r;
  logic [AW-1:0] src_r, dst_r, len_r;
  logic [AW-1:0] rd_cnt, wr_cnt;
  logic [DW-1:0] fill_r, data_reg, checksum_r;

  assign busy         = (state == RUN) || (state == DRAIN);
  assign done         = (state == DONE);
  assign checksum     = checksum_r;
  assign memwrite_1   = 1'b0;
  assign write_data_1 = '0;
  assign memread_2    = 1'b0;

  // Memory-port outputs come only from registered state; inputs affect next state only.
  always_comb begin
    state_next   = state;
    memread_1    = 1'b0;
    address_1    = '0;
    memwrite_2   = 1'b0;
    address_2    = '0;
    write_data_2 = '0;
    case (state)
      IDLE: begin
        if (start) state_next = (length == '0) ? DONE : RUN;
      end
      RUN: begin
        if (!mode_r) begin
          memread_1 = 1'b1;
          address_1 = src_r + rd_cnt;
          if (rd_cnt != '0) begin
            memwrite_2   = 1'b1;
            address_2    = dst_r + wr_cnt;
            write_data_2 = data_reg;
          end
          if (rd_cnt == len_r - ONE) state_next = DRAIN;
        end else begin
          memwrite_2   = 1'b1;
          address_2    = dst_r + wr_cnt;
          write_data_2 = fill_r;
          if (wr_cnt == len_r - ONE) state_next = DONE;
        end
        if (abort) state_next = IDLE;
      end
      DRAIN: begin
        memwrite_2   = 1'b1;
        address_2    = dst_r + wr_cnt;
        write_data_2 = data_reg;
        state_next   = abort ? IDLE : DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Copy is a one-stage pipeline: data_reg carries each read byte to the next cycle's write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_r     <= 1'b0;
      src_r      <= '0;
      dst_r      <= '0;
      len_r      <= '0;
      fill_r     <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      data_reg   <= '0;
      checksum_r <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        mode_r     <= mode;
        src_r      <= src_addr;
        dst_r      <= dst_addr;
        len_r      <= length;
        fill_r     <= fill_value;
        rd_cnt     <= '0;
        wr_cnt     <= '0;
        checksum_r <= '0;
      end
      if (memread_1) begin
        data_reg <= read_data_1;
        rd_cnt   <= rd_cnt + ONE;
      end
      if (memwrite_2) begin
        checksum_r <= checksum_r + write_data_2;
        wr_cnt     <= wr_cnt + ONE;
      end
    end
  end

endmodule
